// File: rtl/cbl_arb_pkg.sv
// Shared types and default sizing for the CaballoLoco memory-port arbiter.
package cbl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int CBL_ARB_DATA_WIDTH     = 32;
    localparam int CBL_ARB_ADDR_WIDTH     = 32;
    localparam int CBL_ARB_FETCH_SLOT     = 4;
    localparam int CBL_ARB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/cbl_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master is the arbiter's view, slave the pipeline/memory view.
interface cbl_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_f;
    logic [ADDR_WIDTH-1:0] addr_f;
    logic                  req_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  done_f;
    logic                  done_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  stall_f;
    logic                  stall_d;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_ack, mem_rdata,
        output done_f, done_d, rdata, err, stall_f, stall_d,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_f, addr_f, req_d, we_d, addr_d, wdata_d, mem_ack, mem_rdata,
        input  done_f, done_d, rdata, err, stall_f, stall_d,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cbl_arb_watchdog.sv
// Watchdog: reloads while load is high, counts while en is high, expire flags the LIMIT-th counted cycle.
// Latency: expire is combinational from the count; no backpressure.
module cbl_arb_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(LIMIT - 1))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = en && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/cbl_mem_arbiter.sv
// Purpose: shares one memory port between fetch and data stages; data wins unless fetch has waited FETCH_SLOT grants.
// Latency: grant->mem_req 1 cycle, mem_ack->done 1 cycle, 3 cycles minimum per access (IDLE/BUSY/DONE).
// Backpressure: stall_* held until done_*; BUSY waits for mem_ack, or watchdog expiry when CBL_ARB_TIMEOUT_EN is defined.
module cbl_mem_arbiter
    import cbl_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = CBL_ARB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = CBL_ARB_ADDR_WIDTH,
    parameter int FETCH_SLOT     = CBL_ARB_FETCH_SLOT,
    parameter int TIMEOUT_CYCLES = CBL_ARB_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    cbl_mem_arbiter_if.master bus
);
    localparam int SW = $clog2(FETCH_SLOT + 1);

    if (FETCH_SLOT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cbl_mem_arbiter: FETCH_SLOT and TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t            state;
    arb_owner_t            owner;
    logic [SW-1:0]         streak;
    logic                  done_f_q;
    logic                  done_d_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  slot_full;
    logic                  grant_d;

    // Fetch only overtakes a pending data request once it has sat out FETCH_SLOT data grants.
    assign slot_full = (streak == SW'(FETCH_SLOT));
    assign grant_d   = bus.req_d && !(bus.req_f && slot_full);

`ifdef CBL_ARB_TIMEOUT_EN
    logic err_q;
    logic expire;

    cbl_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (state == IDLE),
        .en     (state == BUSY),
        .expire (expire)
    );

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWN_F;
            streak      <= '0;
            done_f_q    <= 1'b0;
            done_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef CBL_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_f_q <= 1'b0;
            done_d_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_f || bus.req_d) begin
                        state     <= BUSY;
                        mem_req_q <= 1'b1;
                        if (grant_d) begin
                            owner       <= OWN_D;
                            mem_we_q    <= bus.we_d;
                            mem_addr_q  <= bus.addr_d;
                            mem_wdata_q <= bus.wdata_d;
                            if (!bus.req_f) begin
                                streak <= '0;
                            end else if (!slot_full) begin
                                streak <= streak + SW'(1);
                            end
                        end else begin
                            owner       <= OWN_F;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.addr_f;
                            mem_wdata_q <= '0;
                            streak      <= '0;
                        end
                    end
                end
                BUSY: begin
                    // A real ack beats a watchdog expiry landing in the same cycle.
                    if (bus.mem_ack) begin
                        state     <= DONE;
                        mem_req_q <= 1'b0;
                        rdata_q   <= bus.mem_rdata;
                        done_f_q  <= (owner == OWN_F);
                        done_d_q  <= (owner == OWN_D);
`ifdef CBL_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (expire) begin
                        state     <= DONE;
                        mem_req_q <= 1'b0;
                        rdata_q   <= '0;
                        done_f_q  <= (owner == OWN_F);
                        done_d_q  <= (owner == OWN_D);
                        err_q     <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef CBL_ARB_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.done_f    = done_f_q;
    assign bus.done_d    = done_d_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.stall_f   = bus.req_f && !done_f_q;
    assign bus.stall_d   = bus.req_d && !done_d_q;
endmodule

// File: tb/tb_cbl_mem_arbiter.sv
// Directed bench for cbl_mem_arbiter: vector table of single accesses plus contention, reset, stray-ack and timeout sequences.
module tb_cbl_mem_arbiter;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    cbl_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    cbl_mem_arbiter #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .FETCH_SLOT     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req_f;
        logic [31:0] addr_f;
        logic        req_d;
        logic        we_d;
        logic [31:0] addr_d;
        logic [31:0] wdata_d;
        int          delay;
        logic [31:0] rdat;
        logic        exp_d;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vt[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_all();
        bus.req_f     = 1'b0;
        bus.req_d     = 1'b0;
        bus.we_d      = 1'b0;
        bus.addr_f    = '0;
        bus.addr_d    = '0;
        bus.wdata_d   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        drop_all();
        rst = 1'b0;
        tick();
        tick();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_done", {30'd0, bus.done_f, bus.done_d}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_mem_fields", {31'd0, bus.mem_we} | bus.mem_addr | bus.mem_wdata, 32'd0);
        rst = 1'b1;
        tick();
    endtask

    // One access from IDLE through DONE; leaves the DUT in IDLE with requests dropped.
    task automatic run_vec(input vec_t v);
        int stalls;
        logic [31:0] wd;
        stalls        = 0;
        bus.req_f     = v.req_f;
        bus.addr_f    = v.addr_f;
        bus.req_d     = v.req_d;
        bus.we_d      = v.we_d;
        bus.addr_d    = v.addr_d;
        bus.wdata_d   = v.wdata_d;
        #1;
        if (v.exp_d ? bus.stall_d : bus.stall_f) stalls++;
        tick();
        check("vec_mem_req", 32'(bus.mem_req), 32'd1);
        check("vec_mem_addr", bus.mem_addr, v.exp_addr);
        check("vec_mem_we", 32'(bus.mem_we), 32'(v.exp_we));
        wd = bus.mem_wdata;
        if (v.exp_d) check("vec_mem_wdata", wd, v.exp_wdata);
        for (int k = 1; k < v.delay; k++) begin
            if (v.exp_d ? bus.stall_d : bus.stall_f) stalls++;
            tick();
        end
        if (v.exp_d ? bus.stall_d : bus.stall_f) stalls++;
        check("vec_hold_addr", bus.mem_addr, v.exp_addr);
        check("vec_hold_wdata", bus.mem_wdata, wd);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rdat;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        check("vec_done", {30'd0, bus.done_f, bus.done_d}, v.exp_d ? 32'd1 : 32'd2);
        check("vec_rdata", bus.rdata, v.rdat);
        check("vec_err", 32'(bus.err), 32'd0);
        check("vec_mem_req_off", 32'(bus.mem_req), 32'd0);
        check("vec_stall_cycles", 32'(stalls), 32'(v.delay + 1));
        if (v.exp_d ? bus.stall_d : bus.stall_f) stalls++;
        check("vec_stall_in_done", 32'(stalls), 32'(v.delay + 1));
        drop_all();
        tick();
        check("vec_done_pulse", {30'd0, bus.done_f, bus.done_d}, 32'd0);
    endtask

    task automatic wait_mem_req(output logic ok);
        int n;
        n = 0;
        while (!bus.mem_req && n < 6) begin
            tick();
            n++;
        end
        ok = bus.mem_req;
    endtask

    initial begin
        logic ok;
        logic [31:0] exp_addr;
        int n;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        drop_all();

        //          rf  addr_f        rd  we  addr_d        wdata_d        dly rdat          d   exp_addr      we  exp_wdata
        vt[0] = '{1'b1, 32'h3,       1'b0, 1'b0, 32'h0,    32'h0,        1, 32'hABCD,     1'b0, 32'h3,    1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0,       1'b1, 1'b0, 32'h10,   32'h0,        2, 32'h1234,     1'b1, 32'h10,   1'b0, 32'h0};
        vt[2] = '{1'b0, 32'h0,       1'b1, 1'b1, 32'h2,    32'h7,        5, 32'h0,        1'b1, 32'h2,    1'b1, 32'h7};
        vt[3] = '{1'b1, 32'h44,      1'b0, 1'b1, 32'h66,   32'h99,       3, 32'h5555,     1'b0, 32'h44,   1'b0, 32'h0};
        vt[4] = '{1'b1, 32'h80,      1'b1, 1'b0, 32'h90,   32'h0,        1, 32'h9999,     1'b1, 32'h90,   1'b0, 32'h0};
        vt[5] = '{1'b1, 32'h84,      1'b1, 1'b1, 32'hA0,   32'hDEAD,     2, 32'h0,        1'b1, 32'hA0,   1'b1, 32'hDEAD};
        vt[6] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,  32'h0,        4, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0};

        do_reset();
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Continuous contention: D,D,D,D,F,D,D,D,D then reset during the 4th D of the second run.
        bus.req_f  = 1'b1;
        bus.addr_f = 32'h100;
        bus.req_d  = 1'b1;
        bus.addr_d = 32'h200;
        for (int g = 0; g < 9; g++) begin
            wait_mem_req(ok);
            if (!ok) begin
                check("cont_grant_timeout", 32'(ok), 32'd1);
                break;
            end
            exp_addr = ((g % 5) == 4) ? 32'h100 : 32'h200;
            check("cont_grant", bus.mem_addr, exp_addr);
            if (g == 8) break;
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
            check("cont_done", {30'd0, bus.done_f, bus.done_d}, (exp_addr == 32'h100) ? 32'd2 : 32'd1);
        end

        rst = 1'b0;
        #1;
        check("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rstmid_done", {30'd0, bus.done_f, bus.done_d}, 32'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        check("rstmid_no_done", {30'd0, bus.done_f, bus.done_d}, 32'd0);
        rst = 1'b1;
        tick();
        // Streak was 4 before reset; a cleared streak grants data again.
        check("rstmid_regrant_req", 32'(bus.mem_req), 32'd1);
        check("rstmid_regrant_d", bus.mem_addr, 32'h200);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("rstmid_done_d", {30'd0, bus.done_f, bus.done_d}, 32'd1);
        drop_all();
        tick();

        // Stray ack in IDLE.
        bus.mem_ack = 1'b1;
        tick();
        tick();
        check("stray_idle_done", {30'd0, bus.done_f, bus.done_d}, 32'd0);
        check("stray_idle_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;

        // Ack held through DONE and the following IDLE.
        bus.req_f  = 1'b1;
        bus.addr_f = 32'h300;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h77;
        tick();
        check("stray_done_first", {30'd0, bus.done_f, bus.done_d}, 32'd2);
        check("stray_done_rdata", bus.rdata, 32'h77);
        bus.req_f = 1'b0;
        tick();
        check("stray_done_pulse", {30'd0, bus.done_f, bus.done_d}, 32'd0);
        tick();
        check("stray_after_done", {30'd0, bus.done_f, bus.done_d}, 32'd0);
        check("stray_after_req", 32'(bus.mem_req), 32'd0);
        drop_all();
        tick();
        run_vec(vt[0]);

`ifdef CBL_ARB_TIMEOUT_EN
        // No ack: expiry after 16 BUSY cycles with err=1, rdata=0.
        bus.req_d  = 1'b1;
        bus.addr_d = 32'h55;
        tick();
        n = 0;
        while (!bus.done_d && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'd16);
        check("to_err", 32'(bus.err), 32'd1);
        check("to_rdata", bus.rdata, 32'd0);
        check("to_mem_req", 32'(bus.mem_req), 32'd0);
        drop_all();
        tick();
        // Ack on the 16th BUSY cycle wins over the expiry.
        bus.req_d  = 1'b1;
        bus.addr_d = 32'h56;
        tick();
        for (int k = 1; k < 16; k++) tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBEEF;
        tick();
        drop_all();
        check("to_race_done", {30'd0, bus.done_f, bus.done_d}, 32'd1);
        check("to_race_err", 32'(bus.err), 32'd0);
        check("to_race_rdata", bus.rdata, 32'hBEEF);
        tick();
`else
        n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cbl_mem_arbiter.md
# cbl_mem_arbiter

Arbitrates a single shared memory port between the CaballoLoco pipeline's fetch stage (instruction reads) and memory stage (data loads/stores). It sits between the IF/MEM stages and the unified memory. It serialises accesses through a small FSM and returns per-requester done/stall signals that the hazard logic uses to freeze the pipeline. Data accesses have priority, and a streak counter guarantees fetch forward progress.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 32, word address width
- FETCH_SLOT, 4, max consecutive data grants while fetch waits (≥1)
- TIMEOUT_CYCLES, 16, watchdog limit in BUSY (used only with the watchdog compiled in)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_f  in  1  fetch read request, held until done_f
- addr_f  in  ADDR_WIDTH  fetch address
- req_d  in  1  data request, held until done_d
- we_d  in  1  1 = store, 0 = load
- addr_d  in  ADDR_WIDTH  data address
- wdata_d  in  DATA_WIDTH  store data
- done_f / done_d  out  1  one-cycle completion pulse per requester
- rdata  out  DATA_WIDTH  read data, valid while done_f or done_d is high
- err  out  1  completion was a timeout abort; valid with done_*
- stall_f / stall_d  out  1  req_x & ~done_x (combinational)
- mem_req  out  1  memory access active
- mem_we, mem_addr, mem_wdata  out  1/ADDR/DATA  latched access
- mem_ack  in  1  memory completion; mem_rdata sampled in the same cycle
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any request is pending, latch the owner, address, we and wdata, then go to BUSY.
  - If only one requester is pending, grant it.
  - If both are pending, grant data, unless streak == FETCH_SLOT, in which case grant fetch.
- Fetch grants always have mem_we=0.
- BUSY:
  - mem_req=1 with the latched fields held stable.
  - On mem_ack: register mem_rdata into rdata, set err=0, go to DONE.
- DONE (exactly one cycle):
  - done_<owner>=1; no new grant is made.
  - Go to IDLE. This lets the requester drop or change its request before re-arbitration.
- Streak counter:
  - Increments on a data grant when req_f=1.
  - Clears on a fetch grant, or on a data grant with req_f=0.
  - Saturates at FETCH_SLOT.
- mem_ack outside BUSY is ignored.
- Requests dropped before done are a protocol violation; the access completes regardless.

## Timing
- All outputs except stall_* are registered.
- Reset values: all outputs 0, state IDLE, streak 0.
- Request sampled in IDLE at edge N → mem_req high from N+1.
- mem_ack at edge M → done_x and rdata high for cycle M+1 → IDLE at M+2.
- Minimum access time with zero-wait memory (ack in the first BUSY cycle) is 3 cycles per access; the back-to-back rate is one access per 3 cycles.
- Reset mid-access:
  - Asynchronous.
  - mem_req, done_* and err drop immediately.
  - The access is abandoned and not replayed.

## Configuration
- CBL_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY.
  - After TIMEOUT_CYCLES cycles without mem_ack, mem_req drops and the FSM goes to DONE with err=1 and rdata=0.
  - A mem_ack arriving in the same cycle as the timeout wins: normal completion with err=0.
- CBL_ARB_TIMEOUT_EN undefined:
  - BUSY waits indefinitely.
  - err is tied to 0; the port still exists.

## Structure
- Package cbl_arb_pkg:
  - arb_state_t enum {IDLE, BUSY, DONE}
  - arb_owner_t enum {OWN_F, OWN_D}
  - default parameter constants
- Sub-module cbl_arb_watchdog: a load/count/expire counter, instantiated only under CBL_ARB_TIMEOUT_EN.

## Test plan
- Reset mid-access: rst low while BUSY → mem_req=0 same cycle, no done; after release, IDLE with streak 0.
- Single fetch: req_f with addr_f=3, mem_ack on the first BUSY cycle returning 0xABCD → done_f one cycle later with rdata=0xABCD, stall_f deasserted during done; total 3 cycles.
- Contention: req_f and req_d held continuously, FETCH_SLOT=4 → grant order D,D,D,D,F,D,D,D,D,F…
- Store: req_d with we_d=1, addr_d=2, wdata_d=7, mem_ack after 5 BUSY cycles → mem_we=1, mem_addr=2, mem_wdata=7 held stable; done_d pulses once; stall_d high for 6 cycles.
- Timeout (macro on, TIMEOUT_CYCLES=16): no mem_ack → done pulse with err=1 and rdata=0 after 16 BUSY cycles. With ack on cycle 16 → err=0.
- Stray mem_ack in IDLE/DONE → no done pulse, state unchanged.
